// File: rtl/sisc_ifetch_queue.sv
// Sequential instruction prefetcher feeding a circular queue; entries appear on deq_* one cycle after the memory acknowledge.
// Memory back-pressure holds mem_addr steady; a full queue or halt stops new requests; redirect flushes and refetches.
module sisc_ifetch_queue #(
  parameter int                  WIDTH    = 32,
  parameter int                  ADDRSIZE = 12,
  parameter int                  QDEPTH   = 3,
  parameter logic [ADDRSIZE-1:0] RESET_PC = '0,
  parameter int                  CNTW     = $clog2(QDEPTH+1)
) (
  input  logic                clock,
  input  logic                reset,
  output logic                mem_req,
  output logic [ADDRSIZE-1:0] mem_addr,
  input  logic                mem_ack,
  input  logic [WIDTH-1:0]    mem_rdata,
  output logic                deq_valid,
  output logic [WIDTH-1:0]    deq_instr,
  output logic [ADDRSIZE-1:0] deq_pc,
  input  logic                deq_ready,
  input  logic                redirect,
  input  logic [ADDRSIZE-1:0] redirect_pc,
  input  logic                halt,
  output logic [CNTW-1:0]     qsize,
  output logic                full,
  output logic                empty
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  typedef logic [PW-1:0] ptr_t;
  localparam ptr_t LAST = ptr_t'(QDEPTH - 1);

  logic [WIDTH-1:0]    r_instr [QDEPTH];
  logic [ADDRSIZE-1:0] r_pc    [QDEPTH];
  ptr_t                r_hptr;
  ptr_t                r_tptr;
  logic [CNTW-1:0]     r_qsize;
  logic                r_mem_req;
  logic [ADDRSIZE-1:0] r_fetch_pc;
  logic [WIDTH-1:0]    r_deq_instr;
  logic [ADDRSIZE-1:0] r_deq_pc;

  logic                w_push;
  logic                w_pop;
  ptr_t                w_hptr_inc;
  ptr_t                w_tptr_inc;
  ptr_t                w_hptr_next;
  ptr_t                w_tptr_next;
  logic [CNTW-1:0]     w_qsize_next;
  logic                w_req_next;
  logic [WIDTH-1:0]    w_head_instr;
  logic [ADDRSIZE-1:0] w_head_pc;

  assign w_push     = r_mem_req & mem_ack & ~redirect;
  assign w_pop      = (r_qsize != '0) & deq_ready & ~redirect;
  assign w_hptr_inc = (r_hptr == LAST) ? '0 : r_hptr + ptr_t'(1);
  assign w_tptr_inc = (r_tptr == LAST) ? '0 : r_tptr + ptr_t'(1);

  always_comb begin
    w_hptr_next  = r_hptr;
    w_tptr_next  = r_tptr;
    w_qsize_next = r_qsize;
    if (redirect) begin
      w_hptr_next  = '0;
      w_tptr_next  = '0;
      w_qsize_next = '0;
    end else begin
      if (w_pop)  w_hptr_next = w_hptr_inc;
      if (w_push) w_tptr_next = w_tptr_inc;
      w_qsize_next = r_qsize + CNTW'(w_push) - CNTW'(w_pop);
    end
  end

  // An unacknowledged request is held regardless of halt so the address never changes under memory.
  always_comb begin
    w_req_next = 1'b0;
    if (!redirect) begin
      if (r_mem_req && !mem_ack) w_req_next = 1'b1;
      else                       w_req_next = ~halt & (w_qsize_next < CNTW'(QDEPTH));
    end
  end

  // The next head is the word being written this cycle only when the queue was otherwise empty.
  always_comb begin
    w_head_instr = r_deq_instr;
    w_head_pc    = r_deq_pc;
    if (w_qsize_next != '0) begin
      if (w_push && (w_hptr_next == r_tptr)) begin
        w_head_instr = mem_rdata;
        w_head_pc    = r_fetch_pc;
      end else begin
        w_head_instr = r_instr[w_hptr_next];
        w_head_pc    = r_pc[w_hptr_next];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_instr[r_tptr] <= mem_rdata;
      r_pc[r_tptr]    <= r_fetch_pc;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hptr      <= '0;
      r_tptr      <= '0;
      r_qsize     <= '0;
      r_mem_req   <= 1'b0;
      r_fetch_pc  <= RESET_PC;
      r_deq_instr <= '0;
      r_deq_pc    <= '0;
    end else begin
      r_hptr      <= w_hptr_next;
      r_tptr      <= w_tptr_next;
      r_qsize     <= w_qsize_next;
      r_mem_req   <= w_req_next;
      r_deq_instr <= w_head_instr;
      r_deq_pc    <= w_head_pc;
      if (redirect)    r_fetch_pc <= redirect_pc;
      else if (w_push) r_fetch_pc <= r_fetch_pc + ADDRSIZE'(1);
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_addr  = r_fetch_pc;
  assign qsize     = r_qsize;
  assign full      = (r_qsize == CNTW'(QDEPTH));
  assign empty     = (r_qsize == '0);
  assign deq_valid = ~empty;
  assign deq_instr = r_deq_instr;
  assign deq_pc    = r_deq_pc;

endmodule

// File: tb/tb_sisc_ifetch_queue.sv
// Scoreboard bench for sisc_ifetch_queue: a queue model of fetched words, a driver and a negedge monitor.
module tb_sisc_ifetch_queue;
  localparam int          W   = 32;
  localparam int          A   = 12;
  localparam int          QD  = 3;
  localparam int          CW  = $clog2(QD+1);
  localparam logic [A-1:0] RPC = 12'h000;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          mem_req;
  logic [A-1:0]  mem_addr;
  logic          mem_ack = 1'b0;
  logic [W-1:0]  mem_rdata;
  logic          deq_valid;
  logic [W-1:0]  deq_instr;
  logic [A-1:0]  deq_pc;
  logic          deq_ready = 1'b0;
  logic          redirect = 1'b0;
  logic [A-1:0]  redirect_pc = '0;
  logic          halt = 1'b0;
  logic [CW-1:0] qsize;
  logic          full;
  logic          empty;

  always #5 clock = ~clock;

  function automatic logic [W-1:0] imem(input logic [A-1:0] a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction
  assign mem_rdata = imem(mem_addr);

  sisc_ifetch_queue #(.WIDTH(W), .ADDRSIZE(A), .QDEPTH(QD), .RESET_PC(RPC)) dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .deq_valid(deq_valid),
    .deq_instr(deq_instr), .deq_pc(deq_pc), .deq_ready(deq_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .qsize(qsize), .full(full), .empty(empty)
  );

  typedef struct packed { logic [A-1:0] pc; logic [W-1:0] instr; } ent_t;
  ent_t sb[$];

  int           n_tests = 0;
  int           n_fail  = 0;
  bit           mon_en  = 1'b0;
  bit           m_flush = 1'b0;
  int           exp_qsize = 0;
  bit           exp_req   = 1'b0;
  logic [A-1:0] exp_fetch = RPC;
  logic [A-1:0] m_fetch   = RPC;
  bit           p_ack = 1'b0, p_halt = 1'b0, p_rd = 1'b0;
  logic [A-1:0] last_pc    = '0;
  logic [W-1:0] last_instr = '0;
  bit           r_halt = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares the DUT against the model state and retires the head on a dequeue handshake.
  always @(negedge clock) begin
    if (mon_en) begin
      chk("qsize",     64'(qsize),     64'(exp_qsize));
      chk("full",      64'(full),      64'(exp_qsize == QD));
      chk("empty",     64'(empty),     64'(exp_qsize == 0));
      chk("deq_valid", 64'(deq_valid), 64'(exp_qsize != 0));
      chk("mem_req",   64'(mem_req),   64'(exp_req));
      chk("mem_addr",  64'(mem_addr),  64'(exp_fetch));
      chk("push_when_full", 64'(mem_req && mem_ack && !redirect && full), 64'd0);
      if (exp_qsize != 0 && sb.size() != 0) begin
        last_pc    = sb[0].pc;
        last_instr = sb[0].instr;
      end
      chk("deq_pc",    64'(deq_pc),    64'(last_pc));
      chk("deq_instr", 64'(deq_instr), 64'(last_instr));
      if (exp_qsize != 0 && deq_ready && !redirect && sb.size() != 0)
        void'(sb.pop_front());
    end
  end

  // Driver: advance one edge, settle the model for it, then apply new inputs and record their effect.
  task automatic step(input bit ack, input bit rdy, input bit hlt, input bit rd, input logic [A-1:0] rpc);
    ent_t e;
    @(posedge clock);
    #1;
    if (m_flush) sb.delete();
    m_flush   = 1'b0;
    exp_qsize = sb.size();
    if (p_rd)                exp_req = 1'b0;
    else if (exp_req && !p_ack) exp_req = 1'b1;
    else                     exp_req = !p_halt && (sb.size() < QD);
    exp_fetch = m_fetch;
    mon_en    = 1'b1;
    mem_ack = ack; deq_ready = rdy; halt = hlt; redirect = rd; redirect_pc = rpc;
    p_ack = ack; p_halt = hlt; p_rd = rd;
    if (rd) begin
      m_flush = 1'b1;
      m_fetch = rpc;
    end else if (exp_req && ack) begin
      e.pc = exp_fetch;
      e.instr = imem(exp_fetch);
      sb.push_back(e);
      m_fetch = exp_fetch + 12'd1;
    end
  endtask

  task automatic rand_step();
    if ($urandom_range(0, 15) == 0) r_halt = ~r_halt;
    step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, r_halt,
         $urandom_range(0, 39) == 0, A'($urandom));
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    chk("rst_mem_req",   64'(mem_req),   64'd0);
    chk("rst_mem_addr",  64'(mem_addr),  64'(RPC));
    chk("rst_qsize",     64'(qsize),     64'd0);
    chk("rst_full",      64'(full),      64'd0);
    chk("rst_empty",     64'(empty),     64'd1);
    chk("rst_deq_valid", 64'(deq_valid), 64'd0);
    chk("rst_deq_instr", 64'(deq_instr), 64'd0);
    chk("rst_deq_pc",    64'(deq_pc),    64'd0);
    sb.delete();
    exp_qsize = 0; exp_req = 1'b0; exp_fetch = RPC; m_fetch = RPC; m_flush = 1'b0;
    last_pc = '0; last_instr = '0; r_halt = 1'b0;
    mem_ack = 1'b0; deq_ready = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = '0;
    p_ack = 1'b0; p_halt = 1'b0; p_rd = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    #3;
    do_reset();

    // Fill from reset with the consumer stalled.
    repeat (6) step(1, 0, 0, 0, '0);
    chk("fill_full",  64'(full),    64'd1);
    chk("fill_req",   64'(mem_req), 64'd0);
    chk("fill_qsize", 64'(qsize),   64'd3);
    chk("fill_pc",    64'(deq_pc),  64'd0);

    // One pop while full: refetch of address 3 into the freed slot.
    step(1, 1, 0, 0, '0);
    repeat (3) step(1, 0, 0, 0, '0);
    chk("wrap_pc",    64'(deq_pc), 64'd1);
    chk("wrap_qsize", 64'(qsize),  64'd3);
    repeat (3) step(0, 1, 0, 0, '0);

    // Redirect together with an acknowledge.
    repeat (2) step(0, 0, 0, 0, '0);
    step(1, 1, 0, 1, 12'h0A0);
    step(0, 0, 0, 0, '0);
    chk("redir_qsize", 64'(qsize),   64'd0);
    chk("redir_req",   64'(mem_req), 64'd0);
    step(1, 0, 0, 0, '0);
    chk("redir_req1",  64'(mem_req),  64'd1);
    chk("redir_addr",  64'(mem_addr), 64'h0A0);
    step(0, 0, 0, 0, '0);
    chk("redir_valid", 64'(deq_valid), 64'd1);
    chk("redir_pc",    64'(deq_pc),    64'h0A0);

    // Memory back-pressure with a request pending.
    repeat (5) step(0, 0, 0, 0, '0);
    chk("bp_addr",  64'(mem_addr), 64'h0A1);
    chk("bp_qsize", 64'(qsize),    64'd1);

    // Halt while a request is outstanding; dequeue keeps going.
    step(0, 0, 1, 0, '0);
    step(1, 1, 1, 0, '0);
    repeat (6) step(0, 1, 1, 0, '0);
    chk("halt_req",   64'(mem_req), 64'd0);
    chk("halt_qsize", 64'(qsize),   64'd0);
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    chk("unhalt_req", 64'(mem_req), 64'd1);

    repeat (3000) rand_step();

    // Streaming, then asynchronous reset between edges.
    repeat (20) step(1, 1, 0, 0, '0);
    #2;
    do_reset();
    repeat (10) step(1, 0, 0, 0, '0);
    repeat (800) rand_step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
